button_event_decoder: RTL

Converts the clean, debounced level from the push-button debouncer into single-cycle event pulses: press, release, short click, long press, and auto-repeat while held. It is the consumer of the debouncer output. It sits between each debouncer instance and the board's control logic (menu stepping, value increment, mode select), so that logic never handles raw levels or times presses itself.

---
 rtl/button_event_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns the debounced push-button level into single-cycle event pulses:
// press, release, short click, long press, and auto-repeat while the button
// stays held. Downstream control logic only ever sees these pulses, so it
// never has to time a press itself.
//
// Parameters
//   LONG_CYCLES   hold time in clk cycles before long_press (>= 2)
//   REPEAT_CYCLES period in clk cycles of btn_repeat after long_press (>= 1)
//   CNT_W         counter width, 2**CNT_W >= max(LONG_CYCLES, REPEAT_CYCLES)
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   level_in    debounced level, synchronous to clk, 1 = pressed
//   press       one-cycle pulse on an accepted press
//   btn_release one-cycle pulse on release from a held state
//   click       accompanies btn_release when released before the long threshold
//   long_press  one-cycle pulse when the hold reaches LONG_CYCLES
//   btn_repeat  one-cycle pulse every REPEAT_CYCLES after long_press while held
//   held        level, 1 while PRESSED or LONG
//
// The release and repeat events carry a btn_ prefix because "release" and
// "repeat" are reserved words in SystemVerilog.
// All outputs are registered.

module button_event_decoder #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic level_in,
   output logic press,
   output logic btn_release,
   output logic click,
   output logic long_press,
   output logic btn_repeat,
   output logic held
);

   typedef enum logic [1:0] {
      ST_ARM     = 2'd0,
      ST_IDLE    = 2'd1,
      ST_PRESSED = 2'd2,
      ST_LONG    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              press_s, release_s, click_s, long_s, repeat_s, held_s;
   logic              press_r, release_r, click_r, long_r, repeat_r, held_r;

   // State, counter and registered event outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_ARM;
         cnt_r     <= CNT_ZERO;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         click_r   <= 1'b0;
         long_r    <= 1'b0;
         repeat_r  <= 1'b0;
         held_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         press_r   <= press_s;
         release_r <= release_s;
         click_r   <= click_s;
         long_r    <= long_s;
         repeat_r  <= repeat_s;
         held_r    <= held_s;
      end
   end

   // Next-state, counter and event decode. Release is tested first in the
   // held states so a falling level always wins over a threshold hit.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      click_s   = 1'b0;
      long_s    = 1'b0;
      repeat_s  = 1'b0;
      case (state_r)
         ST_ARM: begin
            // A button held through reset must be seen released first.
            if (!level_in) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_ARM;
            end
         end
         ST_IDLE: begin
            if (level_in) begin
               state_s = ST_PRESSED;
               cnt_s   = CNT_ZERO;
               press_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PRESSED: begin
            if (!level_in) begin
               state_s   = ST_IDLE;
               cnt_s     = CNT_ZERO;
               release_s = 1'b1;
               click_s   = 1'b1;
            end else if (cnt_r == LONG_LAST) begin
               state_s = ST_LONG;
               cnt_s   = CNT_ZERO;
               long_s  = 1'b1;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_LONG: begin
            if (!level_in) begin
               state_s   = ST_IDLE;
               cnt_s     = CNT_ZERO;
               release_s = 1'b1;
            end else if (cnt_r == REPEAT_LAST) begin
               cnt_s    = CNT_ZERO;
               repeat_s = 1'b1;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = ST_ARM;
            cnt_s   = CNT_ZERO;
         end
      endcase
      held_s = (state_s == ST_PRESSED) || (state_s == ST_LONG);
   end

   assign press       = press_r;
   assign btn_release = release_r;
   assign click       = click_r;
   assign long_press  = long_r;
   assign btn_repeat  = repeat_r;
   assign held        = held_r;

endmodule
